// File: rtl/e_mdu.sv
// E-stage multiply/divide unit with architectural HI/LO.
// Fixed-latency results: mult 5 cycles, div 10 cycles.
module e_mdu (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic        md_we,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        hilo_sel,
    input  logic        D_md_req,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] md_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] temp_hi_q;
    logic [31:0] temp_lo_q;
    logic        dz_q;

    logic [63:0] a_ext;
    logic [63:0] b_ext;
    logic [63:0] prod;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_div;
    logic [31:0] uquo;
    logic [31:0] urem;
    logic [31:0] quo;
    logic [31:0] rem;

    // Product and sign-magnitude quotient/remainder of the live operands;
    // md_op[0] selects unsigned for both mult and div.
    always_comb begin
        a_ext = md_op[0] ? {32'b0, A} : {{32{A[31]}}, A};
        b_ext = md_op[0] ? {32'b0, B} : {{32{B[31]}}, B};
        prod  = a_ext * b_ext;
        a_neg = ~md_op[0] & A[31];
        b_neg = ~md_op[0] & B[31];
        a_mag = a_neg ? (32'd0 - A) : A;
        b_mag = b_neg ? (32'd0 - B) : B;
        b_div = (b_mag == 32'd0) ? 32'd1 : b_mag;
        uquo  = a_mag / b_div;
        urem  = a_mag % b_div;
        quo   = (a_neg ^ b_neg) ? (32'd0 - uquo) : uquo;
        rem   = a_neg ? (32'd0 - urem) : urem;
    end

    // Operation sequencer: capture at start, count down, commit on cnt==1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            temp_hi_q <= 32'd0;
            temp_lo_q <= 32'd0;
            dz_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && !md_op[2]) begin
                        if (!md_op[1]) begin
                            temp_hi_q <= prod[63:32];
                            temp_lo_q <= prod[31:0];
                            dz_q      <= 1'b0;
                            cnt_q     <= 4'd5;
                            state_q   <= MUL;
                        end else begin
                            temp_hi_q <= rem;
                            temp_lo_q <= quo;
                            dz_q      <= (B == 32'd0);
                            cnt_q     <= 4'd10;
                            state_q   <= DIV;
                        end
                    end else if (md_we && md_op == 3'd4) begin
                        hi_q <= A;
                    end else if (md_we && md_op == 3'd5) begin
                        lo_q <= A;
                    end
                end
                MUL, DIV: begin
                    if (cnt_q == 4'd1) begin
                        if (!dz_q) begin
                            hi_q <= temp_hi_q;
                            lo_q <= temp_lo_q;
                        end
                        cnt_q   <= 4'd0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    cnt_q   <= 4'd0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy     = (state_q != IDLE);
    assign md_stall = D_md_req & (start | busy);
    assign HI       = hi_q;
    assign LO       = lo_q;
    assign md_out   = hilo_sel ? hi_q : lo_q;

endmodule

// File: doc/e_mdu.md
E_MDU -- requirements
Module: E_MDU

Interface
REQ-001 SHALL provide: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL provide: reset  input  1  asynchronous, active-low reset; asserted (0) clears all state immediately, independent of clk.
REQ-003 SHALL provide: start  input  1  E-stage pulse, high for exactly the cycle a mult/multu/div/divu sits in E.
REQ-004 SHALL provide: md_op  input  3  0=mult, 1=multu, 2=div, 3=divu, 4=mthi, 5=mtlo, 6/7=none.
REQ-005 SHALL provide: md_we  input  1  E-stage write strobe for mthi/mtlo (md_op 4/5 only).
REQ-006 SHALL provide: A  input  32  rs operand (forwarded value).
REQ-007 SHALL provide: B  input  32  rt operand (forwarded value).
REQ-008 SHALL provide: hilo_sel  input  1  0=read LO (mflo), 1=read HI (mfhi).
REQ-009 SHALL provide: D_md_req  input  1  D stage holds any mult/div/mfhi/mflo/mthi/mtlo.
REQ-010 SHALL provide: busy  output  1  operation in progress.
REQ-011 SHALL provide: md_stall  output  1  D-stage stall request to hazard unit, OR-ed with the Tuse/Tnew stall.
REQ-012 SHALL provide: HI  output  32  architectural HI.
REQ-013 SHALL provide: LO  output  32  architectural LO.
REQ-014 SHALL provide: md_out  output  32  hilo_sel ? HI : LO, combinational; Tnew=1 path for mfhi/mflo.

Function
REQ-015 SHALL implement states IDLE, MUL, DIV plus a 4-bit down-counter cnt; busy = (state != IDLE).
REQ-016 IDLE + start + md_op 0/1: SHALL compute the 64-bit product of A, B (signed for 0, unsigned for 1) into temp_hi/temp_lo, load cnt=5, enter MUL.
REQ-017 IDLE + start + md_op 2/3: SHALL compute quotient/remainder (signed for 2, unsigned for 3) into temp_lo/temp_hi, load cnt=10, enter DIV.
REQ-018 In MUL/DIV: cnt SHALL decrement by 1 each cycle; on the edge where cnt==1, HI<=temp_hi, LO<=temp_lo, cnt<=0, state<=IDLE.
REQ-019 Timing: busy high for exactly 5 (mult) or 10 (div) cycles after the start edge; new HI/LO visible on the first cycle busy is low.
REQ-020 Signed division SHALL truncate toward zero; remainder takes dividend's sign; 0x80000000 / 0xFFFFFFFF (div) gives LO=0x80000000, HI=0.
REQ-021 Divide by zero (B==0): SHALL run the full 10 cycles and leave HI/LO unchanged at commit.
REQ-022 md_we with md_op 4 (5) in IDLE SHALL write A to HI (LO) on that edge; no busy cycle.
REQ-023 start or md_we while busy SHALL be ignored (no state change); md_stall prevents this in normal flow.
REQ-024 start with md_op 4-7, or md_we with md_op 0-3/6/7, SHALL be ignored.
REQ-025 md_stall = D_md_req & (start | busy), combinational.
REQ-026 HI/LO reads during busy SHALL return the pre-operation values; md_out never exposes temp_hi/temp_lo.
REQ-027 Operands SHALL be captured at start only; A/B changes during busy have no effect.

Reset
REQ-028 reset=0 SHALL force state=IDLE, cnt=0, HI=0, LO=0, temp_hi=0, temp_lo=0; busy=0; md_stall=D_md_req&start.
REQ-029 reset asserted mid-operation SHALL abort without committing; first post-release cycle IDLE, start accepted.

Verification
REQ-030 mult A=0xFFFFFFFF, B=2 -> busy 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu same operands -> HI=1, LO=0xFFFFFFFE.
REQ-031 div A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=2 -> LO=3, HI=1.
REQ-032 HI=0x12, LO=0x34, div B=0 -> after 10 cycles HI=0x12, LO=0x34 unchanged.
REQ-033 mult in flight, D_md_req=1 -> md_stall=1 all busy cycles; mfhi (hilo_sel=1) during busy -> old HI; md_stall=0 first cycle after commit.
REQ-034 mthi A=0xDEADBEEF, md_we=1 in IDLE -> HI=0xDEADBEEF next cycle, busy stays 0; same while busy -> HI unchanged.
REQ-035 reset low at cycle 3 of div -> HI=LO=0, busy=0 immediately; after release, mult A=3, B=4 -> LO=12, HI=0 after 5 cycles.
